// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: 64-cycle shift/add multiply and
// restoring divide, with a one-cycle done pulse and busy stall output.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quot_n, rem_n;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    result_d = result_q;

    is_div = funct3[2];
    sa     = op_a[XLEN-1] & (is_div ? ~funct3[0]
                                    : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10));
    sb     = op_b[XLEN-1] & (is_div ? ~funct3[0] : (funct3[1:0] == 2'b01));
    mag_a  = sa ? -op_a : op_a;
    mag_b  = sb ? -op_b : op_b;

    sum    = {1'b0, hi_q} + {1'b0, a_q};
    rem_sh = {hi_q, lo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, a_q};

    prod_n = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_n = neg_q ? -lo_q : lo_q;
    rem_n  = neg_q ? -hi_q : hi_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          f3_d  = funct3;
          neg_d = (is_div && funct3[1]) ? sa : (sa ^ sb);
          hi_d  = '0;
          cnt_d = '0;
          // Multiply keeps the multiplier in lo; divide keeps the dividend there.
          a_d   = is_div ? mag_b : mag_a;
          lo_d  = is_div ? mag_a : mag_b;
          state_d = S_CALC;
          if (is_div && op_b == '0) begin
            hi_d    = op_a;
            lo_d    = '1;
            neg_d   = 1'b0;
            state_d = S_FIN;
          end else if (is_div && !funct3[0] && op_a == MIN_NEG && op_b == '1) begin
            hi_d    = '0;
            lo_d    = op_a;
            neg_d   = 1'b0;
            state_d = S_FIN;
          end
        end
      end
      S_CALC: begin
        if (f3_q[2]) begin
          if (!diff[XLEN]) begin
            hi_d = diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          if (lo_q[0]) begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[XLEN-1:1]};
            lo_d = {hi_q[0], lo_q[XLEN-1:1]};
          end
        end
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd63) state_d = S_FIN;
      end
      S_FIN: begin
        unique case (f3_q)
          3'b000:                 result_d = prod_n[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_n[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quot_n;
          default:                result_d = rem_n;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV64M multiply/divide execute unit for `pipelined_datapath`. It accepts one M-extension operation from the EX stage and computes it over 64 shift/add or shift/subtract iterations. It returns a 64-bit result with a one-cycle `done` pulse, and raises `busy` so the hazard unit stalls the pipeline while the operation is in flight. The M-extension register-file bench drives its results into x4–x15.

## Interface
- `XLEN`, 64, operand/result width; the only supported value.
- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  issue strobe; sampled only when the unit is idle.
- `funct3`  input  3  M opcode: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  64  rs1 value.
- `op_b`  input  64  rs2 value.
- `busy`  output  1  operation in flight; the pipeline must stall EX.
- `done`  output  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  output  64  final value; holds until the next `done`.

## Operation
States:
- **IDLE**: waits for `start`.
- **CALC**: iterates using a 7-bit counter.
- **FIN**: applies the sign fix and registers `result`.

IDLE, `start`=1:
- Latch `funct3`.
- Compute operand magnitudes:
  - For signed ops (MULH, DIV, REM), negate a negative `op_a` and a negative `op_b`.
  - For MULHSU, only `op_a` is treated as signed.
  - MUL uses raw operands; its low 64 bits are sign-agnostic.
- Record the result sign:
  - Product sign is `sign_a ^ sign_b`.
  - Quotient sign is `sign_a ^ sign_b`.
  - Remainder sign is `sign_a`.
- Clear the counter and go to CALC.

Special cases, detected in IDLE on `start` for DIV/DIVU/REM/REMU; these skip CALC and go straight to FIN:
- `op_b`=0: quotient = all ones, remainder = `op_a`.
- DIV/REM with `op_a`=0x8000_0000_0000_0000 and `op_b`=all ones: quotient = `op_a`, remainder = 0.

Multiply in CALC:
- Use a 128-bit accumulator {hi, lo}.
- Each cycle, if multiplier bit0 is 1, add the multiplicand into hi (65-bit sum), then shift {carry, hi, lo} right by one.
- 64 iterations.

Divide in CALC:
- Restoring division.
- Each cycle, shift {rem, quot} left by one, trial-subtract the divisor from rem (65-bit).
- If the difference is non-negative, keep it and set quot bit0 = 1.
- 64 iterations.

FIN:
- Select the output:
  - MUL: lo.
  - MULH, MULHSU, MULHU: hi.
  - DIV, DIVU: quot.
  - REM, REMU: rem.
- If the recorded sign is 1, apply two's-complement negation (128-bit for products before the hi/lo select).
- Register `result`, pulse `done`, return to IDLE.

`start` while `busy` is ignored; no queueing and no abort. Operands are captured at issue, so input changes after issue have no effect.

## Timing
- Reset (async assert, synchronous release):
  - `busy`=0, `done`=0, `result`=0, state IDLE, counter 0.
  - Assertion mid-operation aborts it; no `done` is produced.
- `start` high in cycle 0, normal operation:
  - `busy`=1 in cycles 1–65 (64 CALC cycles plus FIN).
  - `done`=1 and `result` valid in cycle 66, with `busy`=0.
- Special-case divide:
  - `busy`=1 in cycle 1 only.
  - `done`=1 in cycle 2.
- `done` is high for exactly one cycle and never coincides with `busy`=1.
- A `start` in the `done` cycle is accepted; back-to-back throughput is one op per 66 cycles.
- `result` changes only on the `done` edge or on reset.
- The stall interface is `busy` only; EX holds `start` and operands while stalled, and re-asserting `start` during `busy` is harmless.

## Test plan
- MUL 15 × −3 → `result`=−45 (0xFFFF_FFFF_FFFF_FFD3), `done` exactly in cycle 66, `busy` high in cycles 1–65.
- MULH(15, −3) → all ones; MULHSU(−3, 200) → all ones; MULHU(15, 200) → 0; MULHU(all ones, all ones) → 0xFFFF_FFFF_FFFF_FFFE.
- DIV(15, −3) → −5; DIVU(200, 15) → 13; DIV(−3, 15) → 0; REM(15, −3) → 0; REMU(200, 15) → 5; REM(−3, 15) → −3; REMU(15, 200) → 15.
- DIVU(7, 0) → all ones and REMU(7, 0) → 7, with `done` in cycle 2. DIV(0x8000…0, −1) → 0x8000…0 and REM of the same operands → 0.
- `start` pulsed every cycle during a MUL, with operands changed mid-op → a single `done` at cycle 66 with the original product. `start` in the `done` cycle → the second op's `done` arrives 66 cycles later.
- `reset_n` low at cycle 30 of a DIV → `busy`, `done` and `result` go to 0 immediately; no `done` follows; the next `start` completes normally.
